// File: rtl/data_mem_pkg.sv
// Shared types and lane-mask constants for the data-memory responder
// and the load/store controller.
package data_mem_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS
   } state_t;

   localparam int NUM_LANES = 4;

   localparam logic [3:0] MASK_B0 = 4'b0001;
   localparam logic [3:0] MASK_B1 = 4'b0010;
   localparam logic [3:0] MASK_B2 = 4'b0100;
   localparam logic [3:0] MASK_B3 = 4'b1000;
   localparam logic [3:0] MASK_H0 = 4'b0011;
   localparam logic [3:0] MASK_H1 = 4'b1100;
   localparam logic [3:0] MASK_W  = 4'b1111;

endpackage

// File: rtl/data_mem_array.sv
// Word-organised data RAM with per-lane write enables and a
// registered read-before-write port.
module data_mem_array
   import data_mem_pkg::*;
#(
   parameter int DWIDTH      = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int IW          = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 hit,
   input  logic [NUM_LANES-1:0] we,
   input  logic [IW-1:0]        idx,
   input  logic [DWIDTH-1:0]    wdata,
   output logic [DWIDTH-1:0]    rdata
);

   localparam int LW = DWIDTH / NUM_LANES;

   logic [DWIDTH-1:0] mem [DEPTH_WORDS];

   // Lane writes; storage itself is never reset.
   always_ff @(posedge clk) begin
      if (en && hit) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (we[i]) begin
               mem[idx][LW*i +: LW] <= wdata[LW*i +: LW];
            end
         end
      end
   end

   // Read port returns the pre-write word, or zero when out of range.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (en) begin
         rdata <= hit ? mem[idx] : '0;
      end
   end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: accepts one request, waits WAIT_STATES
// cycles, performs the access and pulses a one-cycle response.
module data_mem_resp
   import data_mem_pkg::*;
#(
   parameter int DWIDTH      = 32,
   parameter int AWIDTH      = 12,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Req_Valid,
   output logic                 Req_Ready,
   input  logic [AWIDTH-1:0]    Req_Addr,
   input  logic [NUM_LANES-1:0] Req_Write_Ctrl,
   input  logic [DWIDTH-1:0]    Req_Write_Data,
   output logic                 Resp_Valid,
   output logic [DWIDTH-1:0]    Resp_Read_Data,
   output logic                 Resp_Err
);

   localparam int XW = AWIDTH - 2;
   localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   state_t               state;
   logic [3:0]           cnt;
   logic [XW-1:0]        idx_q;
   logic [NUM_LANES-1:0] mask_q;
   logic [DWIDTH-1:0]    data_q;

   logic                 accept;
   logic                 go_access;
   logic                 from_idle;
   logic [XW-1:0]        acc_idx;
   logic [NUM_LANES-1:0] acc_mask;
   logic [DWIDTH-1:0]    acc_data;
   logic                 hit;
   logic                 mem_en;
   logic                 unused_addr_lsb;

   assign unused_addr_lsb = ^Req_Addr[1:0];

   assign Req_Ready = (state == S_IDLE);
   assign accept    = Req_Valid && Req_Ready;

   // The RAM access happens on the edge that enters ACCESS, so the
   // response data is already registered during the ACCESS cycle.
   assign go_access = (accept && (WAIT_STATES == 0))
                   || ((state == S_WAIT) && (cnt == 4'd0));

   assign from_idle = (state == S_IDLE);
   assign acc_idx   = from_idle ? Req_Addr[AWIDTH-1:2] : idx_q;
   assign acc_mask  = from_idle ? Req_Write_Ctrl : mask_q;
   assign acc_data  = from_idle ? Req_Write_Data : data_q;

   assign hit    = 32'(acc_idx) < DEPTH_WORDS;
   assign mem_en = go_access && !Reset;

   data_mem_array #(
      .DWIDTH      (DWIDTH),
      .DEPTH_WORDS (DEPTH_WORDS),
      .IW          (IW)
   ) u_array (
      .clk   (Clk),
      .rst   (Reset),
      .en    (mem_en),
      .hit   (hit),
      .we    (acc_mask),
      .idx   (acc_idx[IW-1:0]),
      .wdata (acc_data),
      .rdata (Resp_Read_Data)
   );

   // Request FSM with registered response strobe and error flag.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= S_IDLE;
         cnt        <= 4'd0;
         idx_q      <= '0;
         mask_q     <= '0;
         data_q     <= '0;
         Resp_Valid <= 1'b0;
         Resp_Err   <= 1'b0;
      end else begin
         Resp_Valid <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  idx_q  <= Req_Addr[AWIDTH-1:2];
                  mask_q <= Req_Write_Ctrl;
                  data_q <= Req_Write_Data;
                  if (WAIT_STATES == 0) begin
                     state      <= S_ACCESS;
                     Resp_Valid <= 1'b1;
                     Resp_Err   <= !hit;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= 4'(WAIT_STATES - 1);
                  end
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) begin
                  state      <= S_ACCESS;
                  Resp_Valid <= 1'b1;
                  Resp_Err   <= !hit;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_ACCESS: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
